// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file's single write port, with forwarding.
// Optional in-place coalescing of duplicate addresses: REGFILE_WBQ_COALESCE_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [AW-1:0]            InAddr,
  input  logic [DW-1:0]            InData,
  input  logic                     Hold,
  output logic                     Write,
  output logic [AW-1:0]            Waddr,
  output logic [DW-1:0]            Wdata,
  input  logic [AW-1:0]            Faddr,
  output logic                     Fhit,
  output logic [DW-1:0]            Fdata,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULLC = (PW+1)'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      cnt;

  logic acc, push, pop;
  logic fhit;
  logic [DW-1:0] fdata;
  logic [PW-1:0] fidx;

  assign Count   = cnt;
  assign Empty   = (cnt == '0);
  assign InReady = (cnt != FULLC);
  assign acc     = InValid && InReady;
  assign Write   = !Empty && !Hold;
  assign pop     = Write;
  assign Waddr   = Empty ? '0 : addr_q[head];
  assign Wdata   = Empty ? '0 : data_q[head];

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fhit  = 1'b0;
    fdata = '0;
    fidx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head + PW'(k);
      if (vld_q[fidx] && addr_q[fidx] == Faddr) begin
        fhit  = 1'b1;
        fdata = data_q[fidx];
      end
    end
  end

  assign Fhit  = fhit && (Faddr != '0);
  assign Fdata = Fhit ? fdata : '0;

`ifdef REGFILE_WBQ_COALESCE_EN
  logic          chit, coal;
  logic [PW-1:0] cidx, sidx;

  always_comb begin
    chit = 1'b0;
    cidx = '0;
    sidx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sidx = head + PW'(k);
      if (vld_q[sidx] && addr_q[sidx] == InAddr) begin
        chit = 1'b1;
        cidx = sidx;
      end
    end
  end

  // A head entry leaving this cycle cannot absorb the new value.
  assign coal = acc && (InAddr != '0) && chit
             && !(cidx == head && Write);
  assign push = acc && (InAddr != '0) && !coal;
`else
  assign push = acc && (InAddr != '0);
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= InAddr;
        data_q[tail] <= InData;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + 1'b1;
      end
`ifdef REGFILE_WBQ_COALESCE_EN
      if (coal)
        data_q[cidx] <= InData;
`endif
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: expected commits queued at accept,
// a negedge monitor pops and compares every Write cycle.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [AW-1:0] InAddr = '0;
  logic [DW-1:0] InData = '0;
  logic          Hold = 1'b0;
  logic          Write;
  logic [AW-1:0] Waddr;
  logic [DW-1:0] Wdata;
  logic [AW-1:0] Faddr = '0;
  logic          Fhit;
  logic [DW-1:0] Fdata;
  logic [2:0]    Count;
  logic          Empty;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  maxcnt;
  int  tries;

  regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InAddr(InAddr), .InData(InData),
    .Hold(Hold),
    .Write(Write), .Waddr(Waddr), .Wdata(Wdata),
    .Faddr(Faddr), .Fhit(Fhit), .Fdata(Fdata),
    .Count(Count), .Empty(Empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (Reset && Write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %0h/%0h expected none",
                 Waddr, Wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (Waddr != e.a || Wdata != e.d) begin
          errors++;
          $display("FAIL commit: got %0h/%0h expected %0h/%0h",
                   Waddr, Wdata, e.a, e.d);
        end
      end
    end
  end

  // Model of the pending list; the monitor has already removed a head
  // that is committing in the cycle we sample.
  task automatic model_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    if (a == '0) return;
`ifdef REGFILE_WBQ_COALESCE_EN
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].a == a) begin
        exp_q[i].d = d;
        return;
      end
    end
`endif
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Inputs change at posedge+1; handshake sampled at negedge+1.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int n);
    logic done;
    done = 1'b0;
    n = 0;
    InValid = 1'b1;
    InAddr  = a;
    InData  = d;
    while (!done && n < 50) begin
      @(negedge clk);
      #1;
      n++;
      if (InReady) begin
        done = 1'b1;
        model_push(a, d);
      end
      @(posedge clk);
      #1;
    end
    InValid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!(Empty && exp_q.size() == 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", int'(Empty), 1);
    chk("drain_sb", exp_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_inready", int'(InReady), 1);
    chk("rst_write", int'(Write), 0);
    chk("rst_waddr", int'(Waddr), 0);
    chk("rst_wdata", int'(Wdata), 0);
    chk("rst_fhit", int'(Fhit), 0);
    chk("rst_fdata", int'(Fdata), 0);
    chk("rst_count", int'(Count), 0);
    chk("rst_empty", int'(Empty), 1);
    @(posedge clk);
    #1;
    Reset = 1'b1;

    // Single write: visible the cycle after acceptance.
    push(5'd3, 16'hBEEF, tries);
    chk("lat_write", int'(Write), 1);
    chk("lat_waddr", int'(Waddr), 3);
    chk("lat_wdata", int'(Wdata), 16'hBEEF);
    @(posedge clk);
    #1;
    chk("lat_empty", int'(Empty), 1);

    // Fill under Hold, then stalled fifth push.
    Hold = 1'b1;
    for (int i = 1; i <= 4; i++)
      push(AW'(i), DW'(i * 16'h0011), tries);
    chk("full_count", int'(Count), 4);
    chk("full_inready", int'(InReady), 0);
    chk("hold_write", int'(Write), 0);
    chk("hold_waddr", int'(Waddr), 1);
    Hold = 1'b0;
    push(5'd5, 16'h0055, tries);
    chk("fifth_wait", tries, 2);
    wait_empty();

    // Forwarding returns youngest duplicate.
    Hold = 1'b1;
    Faddr = 5'd5;
    push(5'd5, 16'h1111, tries);
    push(5'd5, 16'h2222, tries);
    chk("fwd_hit", int'(Fhit), 1);
    chk("fwd_data", int'(Fdata), 16'h2222);
`ifdef REGFILE_WBQ_COALESCE_EN
    chk("dup_count", int'(Count), 1);
`else
    chk("dup_count", int'(Count), 2);
`endif
    Faddr = 5'd6;
    #1;
    chk("fwd_miss", int'(Fhit), 0);
    chk("fwd_miss_data", int'(Fdata), 0);
    Hold = 1'b0;
    wait_empty();

    // r0 writes are swallowed.
    Faddr = 5'd0;
    push(5'd0, 16'hFFFF, tries);
    chk("r0_tries", tries, 1);
    chk("r0_count", int'(Count), 0);
    chk("r0_write", int'(Write), 0);
    chk("r0_fhit", int'(Fhit), 0);

    // Back-to-back stream across pointer wrap.
    maxcnt = 0;
    for (int i = 0; i < 10; i++) begin
      push(AW'(i % 31 + 1), DW'(16'h0A00 + i), tries);
      chk("stream_tries", tries, 1);
      if (int'(Count) > maxcnt) maxcnt = int'(Count);
    end
    chk("stream_maxcnt", maxcnt, 1);
    wait_empty();

    // Async reset discards pending writes.
    Hold = 1'b1;
    push(5'd7, 16'h7777, tries);
    push(5'd8, 16'h8888, tries);
    push(5'd9, 16'h9999, tries);
    chk("pre_rst_count", int'(Count), 3);
    Faddr = 5'd8;
    #1;
    chk("pre_rst_fhit", int'(Fhit), 1);
    Hold = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_write", int'(Write), 0);
    chk("arst_count", int'(Count), 0);
    chk("arst_fhit", int'(Fhit), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    Reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_empty", int'(Empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
